// File: rtl/ysyx_22050612_wbu_if.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050612_wbu_if
//  Purpose  : Bundles every signal of the write-back unit except clk/rst_n:
//             the ALU and LSU result channels, the load-issue notification,
//             the hazard-query ports and the register-file write port.
//  Modports : master - producer/consumer side (pipeline stages, regfile)
//             slave  - the write-back unit itself
//  Revision : 1.0  initial release
// ============================================================================
interface ysyx_22050612_wbu_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  // ALU result channel
  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  // Load response channel
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  // Load issue notification
  logic                  iss_valid;
  logic                  iss_ready;
  logic [ADDR_WIDTH-1:0] iss_rd;
  // Hazard query
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  // Register-file write port and statistics
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [31:0]           wb_count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd,
    output rs1, rs2,
    input  alu_ready, lsu_ready, iss_ready,
    input  rs1_busy, rs2_busy,
    input  wen, waddr, wdata, wb_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd,
    input  rs1, rs2,
    output alu_ready, lsu_ready, iss_ready,
    output rs1_busy, rs2_busy,
    output wen, waddr, wdata, wb_count
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050612_wbu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050612_wbu
//  Purpose  : Write-back unit. Arbitrates ALU and load results onto a single
//             registered register-file write port (load responses win),
//             tracks registers with an outstanding load in a pending
//             scoreboard, and answers rs1/rs2 hazard queries.
//  Ports    : clk    - single clock, rising edge
//             rst_n  - asynchronous active-low reset
//             bus    - ysyx_22050612_wbu_if.slave (handshakes, query, write)
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_22050612_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_22050612_wbu_if.slave        bus
);

  localparam int c_NREG = 2 ** ADDR_WIDTH;

  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [31:0]           r_wb_count;
  logic [c_NREG-1:0]     r_pending;

  logic                  w_lsu_ready;
  logic                  w_alu_ready;
  logic                  w_iss_ready;
  logic                  w_lsu_fire;
  logic                  w_alu_fire;
  logic                  w_fire;
  logic [ADDR_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_rd_nz;
  logic                  w_iss_set;
  logic [c_NREG-1:0]     w_pending_nxt;

  // Readiness is tied to rst_n itself (not a registered copy) so that all
  // ready outputs are low while reset is held and the first transfer after
  // release is taken at the very first edge.
  assign w_lsu_ready = rst_n;
  assign w_alu_ready = rst_n & ~bus.lsu_valid;
  // Bit 0 of the scoreboard is never set, so rd==0 is always ready.
  assign w_iss_ready = rst_n & ~r_pending[bus.iss_rd];

  assign w_lsu_fire  = bus.lsu_valid & w_lsu_ready;
  assign w_alu_fire  = bus.alu_valid & w_alu_ready;
  assign w_fire      = w_lsu_fire | w_alu_fire;
  assign w_rd        = w_lsu_fire ? bus.lsu_rd   : bus.alu_rd;
  assign w_data      = w_lsu_fire ? bus.lsu_data : bus.alu_data;
  assign w_rd_nz     = (w_rd != '0);
  assign w_iss_set   = bus.iss_valid & w_iss_ready & (bus.iss_rd != '0);

  // Clear first, then set, so a same-edge issue to the register whose load
  // is returning leaves it pending. ALU writes never touch the scoreboard.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_lsu_fire) begin
      w_pending_nxt[bus.lsu_rd] = 1'b0;
    end
    if (w_iss_set) begin
      w_pending_nxt[bus.iss_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_wb_count <= '0;
      r_pending  <= '0;
    end else begin
      r_wen     <= w_fire & w_rd_nz;
      r_pending <= w_pending_nxt;
      if (w_fire) begin
        r_waddr <= w_rd;
        r_wdata <= w_data;
      end
      if (w_fire && w_rd_nz) begin
        r_wb_count <= r_wb_count + 32'd1;
      end
    end
  end

  assign bus.lsu_ready = w_lsu_ready;
  assign bus.alu_ready = w_alu_ready;
  assign bus.iss_ready = w_iss_ready;
  assign bus.wen       = r_wen;
  assign bus.waddr     = r_waddr;
  assign bus.wdata     = r_wdata;
  assign bus.wb_count  = r_wb_count;

  // The registered write is visible to the regfile only at the next edge,
  // so a register being written this cycle is still reported busy.
  assign bus.rs1_busy = r_pending[bus.rs1] |
                        (r_wen && (r_waddr == bus.rs1) && (bus.rs1 != '0));
  assign bus.rs2_busy = r_pending[bus.rs2] |
                        (r_wen && (r_waddr == bus.rs2) && (bus.rs2 != '0));

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050612_wbu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_22050612_wbu
//  Purpose  : Directed self-checking bench for ysyx_22050612_wbu. Expected
//             register-file writes are queued when a transfer is driven and
//             popped when the write port shows wen on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_22050612_wbu;

  localparam int AW = 5;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [AW+DW-1:0] sb[$];
  logic             in_reset = 1'b1;

  always #5 clk = ~clk;

  ysyx_22050612_wbu_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ysyx_22050612_wbu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    sb.push_back({rd, d});
  endtask

  // Scoreboard monitor: every wen must match the oldest queued write.
  always @(negedge clk) begin
    if (!in_reset && bus.wen === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {bus.waddr, bus.wdata[58:0]}, 64'hDEAD);
      end else begin
        logic [AW+DW-1:0] e;
        e = sb.pop_front();
        chk("sb_waddr", 64'(bus.waddr), 64'(e[AW+DW-1:DW]));
        chk("sb_wdata", bus.wdata, e[DW-1:0]);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.iss_valid = 0; bus.iss_rd = 0;
    bus.rs1 = 0; bus.rs2 = 0;

    // Reset state, with traffic offered that must be ignored
    repeat (2) cyc();
    bus.alu_valid = 1; bus.alu_rd = 5'd2; bus.alu_data = 64'h55;
    #1;
    chk("rst_wen", 64'(bus.wen), 0);
    chk("rst_waddr", 64'(bus.waddr), 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_wb_count", 64'(bus.wb_count), 0);
    chk("rst_lsu_ready", 64'(bus.lsu_ready), 0);
    chk("rst_alu_ready", 64'(bus.alu_ready), 0);
    chk("rst_iss_ready", 64'(bus.iss_ready), 0);
    cyc();
    bus.alu_valid = 0;
    rst_n = 1; in_reset = 0;
    #1;
    chk("post_rst_lsu_ready", 64'(bus.lsu_ready), 1);
    chk("post_rst_alu_ready", 64'(bus.alu_ready), 1);
    chk("post_rst_iss_ready", 64'(bus.iss_ready), 1);

    // Basic ALU write, latency 1, first edge after reset
    bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 64'h1234;
    push(5'd5, 64'h1234);
    cyc();
    bus.alu_valid = 0; bus.rs1 = 5'd5;
    #1;
    chk("alu_wen", 64'(bus.wen), 1);
    chk("alu_waddr", 64'(bus.waddr), 5);
    chk("alu_wdata", bus.wdata, 64'h1234);
    chk("alu_wb_count", 64'(bus.wb_count), 1);
    chk("alu_rs1_busy_inflight", 64'(bus.rs1_busy), 1);
    cyc();
    chk("idle_wen", 64'(bus.wen), 0);
    chk("idle_waddr_hold", 64'(bus.waddr), 5);
    chk("idle_wdata_hold", bus.wdata, 64'h1234);
    chk("idle_rs1_busy", 64'(bus.rs1_busy), 0);

    // Simultaneous ALU and LSU: load first, ALU one cycle later
    bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_data = 64'hAA;
    bus.lsu_valid = 1; bus.lsu_rd = 5'd4; bus.lsu_data = 64'hBB;
    #1;
    chk("prio_alu_ready", 64'(bus.alu_ready), 0);
    chk("prio_lsu_ready", 64'(bus.lsu_ready), 1);
    push(5'd4, 64'hBB);
    cyc();
    bus.lsu_valid = 0;
    #1;
    chk("prio_waddr", 64'(bus.waddr), 4);
    chk("prio_wdata", bus.wdata, 64'hBB);
    chk("prio_alu_ready_after", 64'(bus.alu_ready), 1);
    push(5'd3, 64'hAA);
    cyc();
    bus.alu_valid = 0;
    chk("prio2_waddr", 64'(bus.waddr), 3);
    chk("prio2_wdata", bus.wdata, 64'hAA);
    chk("prio2_wb_count", 64'(bus.wb_count), 3);

    // Load issue to rd=7, query, then the load returns
    bus.iss_valid = 1; bus.iss_rd = 5'd7;
    #1;
    chk("iss7_ready_before", 64'(bus.iss_ready), 1);
    cyc();
    bus.iss_valid = 0; bus.rs1 = 5'd7; bus.rs2 = 5'd7;
    #1;
    chk("iss7_rs1_busy", 64'(bus.rs1_busy), 1);
    chk("iss7_rs2_busy", 64'(bus.rs2_busy), 1);
    chk("iss7_ready_pending", 64'(bus.iss_ready), 0);
    bus.lsu_valid = 1; bus.lsu_rd = 5'd7; bus.lsu_data = 64'h77;
    push(5'd7, 64'h77);
    cyc();
    bus.lsu_valid = 0;
    #1;
    chk("ld7_rs1_busy_wen_cycle", 64'(bus.rs1_busy), 1);
    cyc();
    chk("ld7_rs1_busy_done", 64'(bus.rs1_busy), 0);
    chk("ld7_iss_ready_done", 64'(bus.iss_ready), 1);
    chk("ld7_wb_count", 64'(bus.wb_count), 4);

    // rd==0 is accepted but never written or counted; issue to rd0 is a no-op
    bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_data = 64'hFF;
    bus.iss_valid = 1; bus.iss_rd = 5'd0;
    #1;
    chk("rd0_alu_ready", 64'(bus.alu_ready), 1);
    chk("rd0_iss_ready", 64'(bus.iss_ready), 1);
    cyc();
    bus.alu_valid = 0; bus.iss_valid = 0; bus.rs1 = 5'd0;
    #1;
    chk("rd0_wen", 64'(bus.wen), 0);
    chk("rd0_wb_count", 64'(bus.wb_count), 4);
    chk("rd0_rs1_busy", 64'(bus.rs1_busy), 0);

    // ALU write to a pending register does not clear it
    bus.iss_valid = 1; bus.iss_rd = 5'd10;
    cyc();
    bus.iss_valid = 0;
    bus.alu_valid = 1; bus.alu_rd = 5'd10; bus.alu_data = 64'h1010;
    push(5'd10, 64'h1010);
    cyc();
    bus.alu_valid = 0; bus.rs1 = 5'd10;
    cyc();
    chk("alu_pend_rs1_busy", 64'(bus.rs1_busy), 1);
    chk("alu_pend_wb_count", 64'(bus.wb_count), 5);
    bus.lsu_valid = 1; bus.lsu_rd = 5'd10; bus.lsu_data = 64'hA0A0;
    push(5'd10, 64'hA0A0);
    cyc();
    bus.lsu_valid = 0;
    cyc();
    chk("pend10_cleared", 64'(bus.rs1_busy), 0);

    // Same-edge issue and load return to rd=9: set wins
    bus.iss_valid = 1; bus.iss_rd = 5'd9;
    bus.lsu_valid = 1; bus.lsu_rd = 5'd9; bus.lsu_data = 64'h9999;
    push(5'd9, 64'h9999);
    cyc();
    bus.iss_valid = 0; bus.lsu_valid = 0; bus.rs2 = 5'd9;
    cyc();
    chk("same9_rs2_busy", 64'(bus.rs2_busy), 1);
    chk("same9_iss_ready", 64'(bus.iss_ready), 0);
    chk("same9_wb_count", 64'(bus.wb_count), 7);

    // Mid-operation reset drops the in-flight write
    bus.alu_valid = 1; bus.alu_rd = 5'd12; bus.alu_data = 64'hC0C0;
    cyc();
    bus.alu_valid = 0;
    #1;
    chk("midrst_wen_before", 64'(bus.wen), 1);
    in_reset = 1; rst_n = 0;
    #1;
    chk("midrst_wen", 64'(bus.wen), 0);
    chk("midrst_wb_count", 64'(bus.wb_count), 0);
    chk("midrst_alu_ready", 64'(bus.alu_ready), 0);
    cyc();
    rst_n = 1; in_reset = 0;
    bus.rs1 = 5'd10; bus.rs2 = 5'd9; bus.iss_rd = 5'd9;
    #1;
    chk("after_rst_rs1_busy", 64'(bus.rs1_busy), 0);
    chk("after_rst_rs2_busy", 64'(bus.rs2_busy), 0);
    chk("after_rst_iss_ready", 64'(bus.iss_ready), 1);
    chk("after_rst_wb_count", 64'(bus.wb_count), 0);
    repeat (3) cyc();
    chk("sb_drained", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22050612_wbu.md
YSYX_22050612_WBU -- requirements
Module: ysyx_22050612_wbu

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register-index width; the register count is 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 64, register data width.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 alu_valid / alu_ready  input / output  1 / 1  ALU result handshake.
REQ-006 alu_rd / alu_data  input  ADDR_WIDTH / DATA_WIDTH  ALU destination register and result.
REQ-007 lsu_valid / lsu_ready  input / output  1 / 1  load-response handshake.
REQ-008 lsu_rd / lsu_data  input  ADDR_WIDTH / DATA_WIDTH  load destination register and data.
REQ-009 iss_valid / iss_ready  input / output  1 / 1  load-issue notification, used to mark rd pending.
REQ-010 iss_rd  input  ADDR_WIDTH  destination of the issued load.
REQ-011 rs1 / rs2  input  ADDR_WIDTH  hazard-query indices.
REQ-012 rs1_busy / rs2_busy  output  1  queried register awaits a load.
REQ-013 wen / waddr / wdata  output  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port, registered.
REQ-014 wb_count  output  32  count of committed nonzero-rd writes.

Function
REQ-015 A transfer on a channel SHALL occur when its valid and ready are both 1 at posedge clk.
REQ-016 lsu_ready SHALL be constant 1 out of reset; alu_ready SHALL equal !lsu_valid, so a load response has priority.
REQ-017 The accepted transfer SHALL be registered: wen/waddr/wdata SHALL reflect it in the cycle after acceptance, i.e. latency 1; the register file commits at the following edge.
REQ-018 With no transfer at an edge, wen SHALL be 0 in the next cycle, and waddr/wdata SHALL hold their previous values.
REQ-019 A transfer with rd==0 SHALL be accepted (ready unaffected) but SHALL produce wen=0.
REQ-020 The pending vector SHALL be 2**ADDR_WIDTH bits; bit 0 SHALL always read 0.
REQ-021 When iss_valid && iss_ready && iss_rd!=0, the block SHALL set pending[iss_rd] at the edge.
REQ-022 An accepted LSU transfer SHALL clear pending[lsu_rd] at the edge.
REQ-023 If the same rd is set and cleared at one edge, the set SHALL win.
REQ-024 iss_ready SHALL equal !pending[iss_rd] (combinational), forbidding two outstanding loads to one rd; iss_rd==0 SHALL always be ready.
REQ-025 rsN_busy SHALL be pending[rsN] OR (wen && waddr==rsN && rsN!=0), combinational, covering the write-not-yet-committed cycle.
REQ-026 An accepted ALU transfer to a pending rd SHALL still be written, and SHALL NOT clear pending.
REQ-027 wb_count SHALL increment by 1 per edge at which a nonzero-rd transfer is accepted, and SHALL wrap 0xFFFFFFFF->0.

Reset
REQ-028 While rst_n==0, regardless of clk: wen=0, waddr=0, wdata=0, pending all 0, wb_count=0, lsu_ready=0, alu_ready=0, iss_ready=0.
REQ-029 Reset asserted mid-operation SHALL drop any in-flight registered write (wen=0 immediately) with no partial commit.
REQ-030 After rst_n rises, the first transfer SHALL be accepted at the first posedge at which valid=1.

Verification
REQ-031 alu_valid=1, alu_rd=5, alu_data=0x1234 at edge N -> cycle N+1: wen=1, waddr=5, wdata=0x1234; wb_count=1.
REQ-032 alu_valid=1 (rd=3, 0xAA) and lsu_valid=1 (rd=4, 0xBB) in the same cycle -> alu_ready=0; next cycle waddr=4, wdata=0xBB; ALU result is written one cycle after lsu_valid drops.
REQ-033 iss rd=7 -> rs1=7 gives rs1_busy=1 and iss_ready for rd=7 is 0; LSU rd=7 accepted -> rs1_busy stays 1 during the wen cycle, then 0.
REQ-034 alu_rd=0, data 0xFF, accepted -> wen stays 0 and wb_count is unchanged.
REQ-035 Same-edge iss rd=9 and LSU rd=9 accepted -> pending[9] remains 1.
REQ-036 rst_n pulled low between edges while wen=1 -> wen=0 immediately; after release all busy outputs=0 and wb_count=0.
